// File: rtl/cancid_stream_sequencer_if.sv
// Packet ingress stream for cancid_stream_sequencer.
// Carries byte data with sop/eop framing, the per-packet flow key and the ready handshake.
interface cancid_stream_sequencer_if;
    logic [7:0]  pkt_data;
    logic        pkt_vld;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [15:0] pkt_flow_key;
    logic        pkt_rdy;

    modport master (output pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_flow_key, input pkt_rdy);
    modport slave  (input pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_flow_key, output pkt_rdy);
endinterface

// File: rtl/cancid_stream_sequencer.sv
// Packet-to-regex-finger sequencer: stream table lookup, state load handshake, byte streaming and drain.
// Optional statistics counters are built when CANCID_SEQ_STATS_EN is defined.
module cancid_stream_sequencer (
    input  logic                        clk,
    input  logic                        rst,
    cancid_stream_sequencer_if.slave    pkt,
    input  logic [63:0]                 cfg_enable_mask,
    input  logic                        cfg_table_clr,
    output logic [7:0]                  char_in,
    output logic                        char_in_vld,
    output logic                        eop,
    output logic                        load_state,
    output logic [5:0]                  stream_id,
    output logic                        new_stream_id,
    output logic                        enable,
    output logic                        proto_err
`ifdef CANCID_SEQ_STATS_EN
    ,
    output logic [31:0]                 stat_pkts,
    output logic [31:0]                 stat_new_streams,
    output logic [15:0]                 stat_errs
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_LOAD, S_WAIT, S_STREAM, S_DRAIN1, S_DRAIN2
    } state_t;

    state_t      state_reg;
    logic [15:0] key_reg;
    logic [63:0] valid_reg;
    logic [9:0]  tag_mem [64];
    logic [9:0]  tag_rd_reg;
    logic        first_reg;
    logic        hit;
    logic        sop_abort;
    logic        stream_xfer;
    logic        tbl_wr;

    assign hit         = valid_reg[key_reg[5:0]] & (tag_rd_reg == key_reg[15:6]);
    // The packet's own sop beat is legal as the first STREAM byte; any later sop ends the packet.
    assign sop_abort   = (state_reg == S_STREAM) & pkt.pkt_vld & pkt.pkt_sop & ~first_reg;
    assign stream_xfer = (state_reg == S_STREAM) & pkt.pkt_vld & ~sop_abort;
    assign tbl_wr      = (state_reg == S_LOAD) & new_stream_id;

    always_comb begin
        pkt.pkt_rdy = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_IDLE:   pkt.pkt_rdy = pkt.pkt_vld & ~pkt.pkt_sop;
                S_STREAM: pkt.pkt_rdy = ~sop_abort;
                default:  pkt.pkt_rdy = 1'b0;
            endcase
        end
    end

    // Tag storage: registered read while idle, so the last IDLE cycle (the sop beat) leaves the entry for LOOKUP.
    always_ff @(posedge clk) begin
        if (tbl_wr)
            tag_mem[stream_id] <= key_reg[15:6];
        if (state_reg == S_IDLE)
            tag_rd_reg <= tag_mem[pkt.pkt_flow_key[5:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (cfg_table_clr) begin
            valid_reg <= '0;
        end else if (tbl_wr) begin
            valid_reg[stream_id] <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            key_reg       <= '0;
            first_reg     <= 1'b0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            load_state    <= 1'b0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            enable        <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            char_in_vld <= 1'b0;
            eop         <= 1'b0;
            load_state  <= 1'b0;
            proto_err   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (pkt.pkt_vld && pkt.pkt_sop) begin
                        key_reg   <= pkt.pkt_flow_key;
                        state_reg <= S_LOOKUP;
                    end else if (pkt.pkt_vld) begin
                        proto_err <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    // enable is captured together with stream_id so all three are stable while load_state is high.
                    stream_id     <= key_reg[5:0];
                    new_stream_id <= ~hit;
                    enable        <= cfg_enable_mask[key_reg[5:0]];
                    load_state    <= 1'b1;
                    state_reg     <= S_LOAD;
                end
                S_LOAD: begin
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    first_reg <= 1'b1;
                    state_reg <= S_STREAM;
                end
                S_STREAM: begin
                    if (sop_abort) begin
                        proto_err <= 1'b1;
                        state_reg <= S_DRAIN1;
                    end else if (stream_xfer) begin
                        first_reg   <= 1'b0;
                        char_in     <= pkt.pkt_data;
                        char_in_vld <= 1'b1;
                        if (pkt.pkt_eop)
                            state_reg <= S_DRAIN1;
                    end
                end
                S_DRAIN1: begin
                    state_reg <= S_DRAIN2;
                end
                S_DRAIN2: begin
                    eop       <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CANCID_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkts        <= '0;
            stat_new_streams <= '0;
            stat_errs        <= '0;
        end else begin
            if (state_reg == S_DRAIN2)
                stat_pkts <= stat_pkts + 32'd1;
            if (tbl_wr)
                stat_new_streams <= stat_new_streams + 32'd1;
            if (proto_err)
                stat_errs <= stat_errs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cancid_stream_sequencer.sv
// Scoreboard bench for cancid_stream_sequencer: the driver queues expected loads, chars and eops;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cancid_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cfg_enable_mask;
    logic        cfg_table_clr;
    logic [7:0]  char_in;
    logic        char_in_vld;
    logic        eop;
    logic        load_state;
    logic [5:0]  stream_id;
    logic        new_stream_id;
    logic        enable;
    logic        proto_err;
`ifdef CANCID_SEQ_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_new_streams;
    logic [15:0] stat_errs;
`endif

    cancid_stream_sequencer_if pkt_if ();

    cancid_stream_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .pkt             (pkt_if),
        .cfg_enable_mask (cfg_enable_mask),
        .cfg_table_clr   (cfg_table_clr),
        .char_in         (char_in),
        .char_in_vld     (char_in_vld),
        .eop             (eop),
        .load_state      (load_state),
        .stream_id       (stream_id),
        .new_stream_id   (new_stream_id),
        .enable          (enable),
        .proto_err       (proto_err)
`ifdef CANCID_SEQ_STATS_EN
        ,
        .stat_pkts        (stat_pkts),
        .stat_new_streams (stat_new_streams),
        .stat_errs        (stat_errs)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] id;
        logic       nw;
        logic       en;
        int         delta;
    } hdr_t;

    hdr_t       load_q[$];
    hdr_t       eop_q[$];
    logic [7:0] char_q[$];
    int         err_exp = 0;
    int         err_seen = 0;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Monitor
    hdr_t cur;
    int   load_cyc = 0;
    int   last_char_cyc = 0;
    bit   first_pending = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (load_state) begin
                if (load_q.size() == 0) begin
                    flag_fail("load_unexpected");
                end else begin
                    cur = load_q.pop_front();
                    check("load_stream_id", 64'(stream_id), 64'(cur.id));
                    check("load_new_stream_id", 64'(new_stream_id), 64'(cur.nw));
                    check("load_enable", 64'(enable), 64'(cur.en));
                    load_cyc      = cyc;
                    first_pending = 1'b1;
                end
            end
            if (char_in_vld) begin
                if (char_q.size() == 0) begin
                    flag_fail("char_unexpected");
                end else begin
                    check("char_in", 64'(char_in), 64'(char_q.pop_front()));
                end
                if (first_pending) begin
                    check("first_char_latency", 64'(cyc - load_cyc), 64'd3);
                    first_pending = 1'b0;
                end
                check("ctx_held_on_char", 64'({stream_id, new_stream_id, enable}), 64'({cur.id, cur.nw, cur.en}));
                last_char_cyc = cyc;
            end
            if (eop) begin
                if (eop_q.size() == 0) begin
                    flag_fail("eop_unexpected");
                end else begin
                    hdr_t e;
                    e = eop_q.pop_front();
                    check("eop_ctx", 64'({stream_id, new_stream_id, enable}), 64'({e.id, e.nw, e.en}));
                    check("eop_latency", 64'(cyc - last_char_cyc), 64'(e.delta));
                end
            end
            if (proto_err)
                err_seen++;
        end
    end

    task automatic send_pkt(input logic [15:0] key, input int n, input bit with_eop,
                            input bit exp_new, input bit exp_en, input int eop_delta);
        hdr_t       h;
        logic [7:0] b;
        int         wait_cyc;
        bit         timed_out;
        h.id = key[5:0];
        h.nw = exp_new;
        h.en = exp_en;
        h.delta = eop_delta;
        load_q.push_back(h);
        if (eop_delta > 0)
            eop_q.push_back(h);
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = key[7:0] + 8'(i * 37 + 1);
            char_q.push_back(b);
            pkt_if.pkt_data     = b;
            pkt_if.pkt_vld      = 1'b1;
            pkt_if.pkt_sop      = (i == 0);
            pkt_if.pkt_eop      = with_eop && (i == n - 1);
            pkt_if.pkt_flow_key = (i == 0) ? key : ~key;
            wait_cyc = 0;
            forever begin
                @(negedge clk);
                if (pkt_if.pkt_rdy) begin
                    @(posedge clk);
                    #1;
                    break;
                end
                @(posedge clk);
                #1;
                wait_cyc++;
                if (wait_cyc > 40) begin
                    $display("FAIL xfer_timeout: got no pkt_rdy for key %0h byte %0d expected transfer", key, i);
                    tests++;
                    fails++;
                    timed_out = 1'b1;
                    break;
                end
            end
            if (timed_out)
                break;
        end
        pkt_if.pkt_vld = 1'b0;
        pkt_if.pkt_sop = 1'b0;
        pkt_if.pkt_eop = 1'b0;
    endtask

    task automatic send_junk(input int n);
        int wait_cyc;
        for (int i = 0; i < n; i++) begin
            err_exp++;
            pkt_if.pkt_data = 8'hA0 + 8'(i);
            pkt_if.pkt_vld  = 1'b1;
            pkt_if.pkt_sop  = 1'b0;
            pkt_if.pkt_eop  = (i == n - 1);
            wait_cyc = 0;
            forever begin
                @(negedge clk);
                if (pkt_if.pkt_rdy) begin
                    @(posedge clk);
                    #1;
                    break;
                end
                @(posedge clk);
                #1;
                wait_cyc++;
                if (wait_cyc > 40) begin
                    $display("FAIL junk_timeout: got no pkt_rdy for junk byte %0d expected discard", i);
                    tests++;
                    fails++;
                    break;
                end
            end
        end
        pkt_if.pkt_vld = 1'b0;
        pkt_if.pkt_eop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pkt_rdy"}, 64'(pkt_if.pkt_rdy), 64'd0);
        check({tag, "_char"}, 64'({char_in, char_in_vld}), 64'd0);
        check({tag, "_eop_load_err"}, 64'({eop, load_state, proto_err}), 64'd0);
        check({tag, "_ctx"}, 64'({stream_id, new_stream_id, enable}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pkt_if.pkt_data     = '0;
        pkt_if.pkt_vld      = 1'b0;
        pkt_if.pkt_sop      = 1'b0;
        pkt_if.pkt_eop      = 1'b0;
        pkt_if.pkt_flow_key = '0;
        cfg_enable_mask     = '1;
        cfg_table_clr       = 1'b0;
        rst                 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pkt_if.pkt_vld = 1'b1;
        #1;
        check_reset_outputs("reset");
        pkt_if.pkt_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // New stream, then a repeat hit, then a same-index different-tag replacement.
        send_pkt(16'h1243, 4, 1'b1, 1'b1, 1'b1, 2);
        send_pkt(16'h1243, 3, 1'b1, 1'b0, 1'b1, 2);
        send_pkt(16'h0043, 2, 1'b1, 1'b1, 1'b1, 2);
        send_pkt(16'h1243, 2, 1'b1, 1'b1, 1'b1, 2);

        // Enable bit 3 cleared, then set mid-packet: that packet keeps enable 0.
        cfg_enable_mask[3] = 1'b0;
        fork
            send_pkt(16'h1243, 5, 1'b1, 1'b0, 1'b0, 2);
            begin
                repeat (9) @(posedge clk);
                #1;
                cfg_enable_mask[3] = 1'b1;
            end
        join
        send_pkt(16'h1243, 1, 1'b1, 1'b0, 1'b1, 2);

        send_junk(2);

        // Table clear forces a miss on a previously known key.
        cfg_table_clr = 1'b1;
        @(posedge clk);
        #1;
        cfg_table_clr = 1'b0;
        send_pkt(16'h1243, 3, 1'b1, 1'b1, 1'b1, 2);
        send_pkt(16'h7FC5, 2, 1'b1, 1'b1, 1'b1, 2);

        // sop during STREAM: error pulse, drain, the sop beat then opens the next packet.
        send_pkt(16'h0A01, 2, 1'b0, 1'b1, 1'b1, 3);
        err_exp++;
        send_pkt(16'h0A01, 3, 1'b1, 1'b0, 1'b1, 2);

        // Reset in the middle of STREAM.
        send_pkt(16'h2222, 2, 1'b0, 1'b1, 1'b1, 0);
        pkt_if.pkt_vld = 1'b1;
        pkt_if.pkt_sop = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midpkt_reset");
        char_q.delete();
        eop_q.delete();
        load_q.delete();
        pkt_if.pkt_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_junk(2);
        send_pkt(16'h1243, 1, 1'b1, 1'b1, 1'b1, 2);
        repeat (10) @(posedge clk);
        #1;

`ifdef CANCID_SEQ_STATS_EN
        check("stat_pkts", 64'(stat_pkts), 64'd1);
        check("stat_new_streams", 64'(stat_new_streams), 64'd1);
        check("stat_errs", 64'(stat_errs), 64'd2);
`endif
        check("load_q_drained", 64'(load_q.size()), 64'd0);
        check("char_q_drained", 64'(char_q.size()), 64'd0);
        check("eop_q_drained", 64'(eop_q.size()), 64'd0);
        check("proto_err_count", 64'(err_seen), 64'(err_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
